// File: rtl/l2_line_responder.sv
// l2_line_responder
//
// L2-side responder for the L1 data cache miss interface. Each accepted
// request moves one 64-byte line as a burst of 32-bit words over a
// word-wide memory port. A fill returns the assembled line with a
// single-cycle ack. A writeback streams the captured line out, then acks.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   l2_read_i        L1 line read (fill) request, level, held until ack
//   l2_write_i       L1 line writeback request, level, held until ack
//   l2_addr_i[31:0]  request address, line offset bits ignored
//   l2_data_i[511:0] writeback line from L1
//   l2_ack_o         single-cycle completion pulse
//   l2_data_o[511:0] fill line to L1, valid in the ack cycle
//   mem_read_o       word read request, held until mem_ack_i
//   mem_write_o      word write request, held until mem_ack_i
//   mem_addr_o[31:0] word byte address
//   mem_data_o[31:0] word write data
//   mem_data_i[31:0] word read data, valid with mem_ack_i
//   mem_ack_i        word transfer complete
//
// Word i of a line sits at base + 4*i and occupies the line bits
// [511-32*i : 480-32*i], so word 0 is the most significant word.
// All outputs come straight from registers. l2_ack_o therefore has no
// combinational path from the request lines, which the L1 drops
// combinationally in the ack cycle.

module l2_line_responder #(
    parameter int BURST_WORDS      = 16,
    parameter int LINE_OFFSET_BITS = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         l2_read_i,
    input  logic         l2_write_i,
    input  logic [31:0]  l2_addr_i,
    input  logic [511:0] l2_data_i,
    output logic         l2_ack_o,
    output logic [511:0] l2_data_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_data_o,
    input  logic [31:0]  mem_data_i,
    input  logic         mem_ack_i
);

    localparam int LINE_BITS = 32 * BURST_WORDS;
    localparam int CNT_W     = $clog2(BURST_WORDS);
    // Masking with a constant (rather than slicing) keeps every address bit
    // formally in use while still forcing the line offset to zero.
    localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_CAPTURE,
        WRITE_BURST,
        READ_BURST,
        ACK
    } state_t;

    state_t                 state_reg,     state_next;
    logic [CNT_W-1:0]       count_reg,     count_next;
    logic [LINE_BITS-1:0]   line_reg,      line_next;
    logic [LINE_BITS-1:0]   l2_data_reg,   l2_data_next;
    logic                   ack_reg,       ack_next;
    logic                   mem_read_reg,  mem_read_next;
    logic                   mem_write_reg, mem_write_next;
    logic [31:0]            mem_addr_reg,  mem_addr_next;
    logic [31:0]            mem_data_reg,  mem_data_next;

    logic [31:0]            line_words [BURST_WORDS];
    logic [LINE_BITS-1:0]   line_merged;
    logic                   store_word;
    logic [CNT_W-1:0]       count_inc;
    logic [31:0]            req_base;

    assign store_word = (state_reg == READ_BURST) && mem_ack_i;
    assign count_inc  = count_reg + CNT_W'(1);
    assign req_base   = l2_addr_i & LINE_MASK;

    // Word view of the line buffer, plus the buffer with the incoming read
    // word dropped into the slot selected by the counter. The merged view
    // lets the final word reach l2_data_o in the same edge that stores it.
    generate
        for (genvar gi = 0; gi < BURST_WORDS; gi++) begin : g_word
            localparam int HI = LINE_BITS - 1 - 32 * gi;
            assign line_words[gi] = line_reg[HI -: 32];
            assign line_merged[HI -: 32] =
                (store_word && (count_reg == CNT_W'(gi))) ? mem_data_i
                                                          : line_reg[HI -: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            line_reg      <= '0;
            l2_data_reg   <= '0;
            ack_reg       <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            line_reg      <= line_next;
            l2_data_reg   <= l2_data_next;
            ack_reg       <= ack_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_data_reg  <= mem_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        line_next      = line_reg;
        l2_data_next   = l2_data_reg;
        ack_next       = 1'b0;
        mem_read_next  = mem_read_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_data_next  = mem_data_reg;

        case (state_reg)
            IDLE: begin
                // The address register doubles as the latched line base; no
                // memory request is raised yet, so updating it early is safe.
                if (l2_write_i) begin
                    mem_addr_next = req_base;
                    state_next    = WRITE_CAPTURE;
                end else if (l2_read_i) begin
                    mem_addr_next = req_base;
                    mem_read_next = 1'b1;
                    state_next    = READ_BURST;
                end
            end

            WRITE_CAPTURE: begin
                // The L1 data RAM needs a cycle after acceptance to present
                // the victim line, so it is sampled here, not in IDLE.
                line_next      = l2_data_i;
                mem_write_next = 1'b1;
                mem_data_next  = l2_data_i[LINE_BITS-1 -: 32];
                state_next     = WRITE_BURST;
            end

            WRITE_BURST: begin
                if (mem_ack_i) begin
                    if (count_reg == LAST_WORD) begin
                        mem_write_next = 1'b0;
                        count_next     = '0;
                        ack_next       = 1'b1;
                        state_next     = ACK;
                    end else begin
                        count_next    = count_inc;
                        mem_addr_next = mem_addr_reg + 32'd4;
                        mem_data_next = line_words[count_inc];
                    end
                end
            end

            READ_BURST: begin
                if (mem_ack_i) begin
                    line_next = line_merged;
                    if (count_reg == LAST_WORD) begin
                        mem_read_next = 1'b0;
                        count_next    = '0;
                        ack_next      = 1'b1;
                        l2_data_next  = line_merged;
                        state_next    = ACK;
                    end else begin
                        count_next    = count_inc;
                        mem_addr_next = mem_addr_reg + 32'd4;
                    end
                end
            end

            ACK: begin
                // Always return through IDLE so an ack is never followed
                // immediately by an acceptance of the still-high request.
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign l2_ack_o    = ack_reg;
    assign l2_data_o   = l2_data_reg;
    assign mem_read_o  = mem_read_reg;
    assign mem_write_o = mem_write_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_data_o  = mem_data_reg;

endmodule
